// File: rtl/rx78_plane_fetch.sv
// rtl/rx78_plane_fetch.sv - prefetches six VRAM bitplane bytes per 8-pixel cell
// and presents them beam-aligned to the colour stage.
module rx78_plane_fetch #(
    parameter int unsigned H_ACTIVE     = 192,
    parameter int unsigned V_ACTIVE     = 184,
    parameter int unsigned H_TOTAL      = 256,
    parameter int unsigned LINE_BYTES   = 24,
    parameter logic [15:0] PLANE_BASE   = 16'h0ec0,
    parameter logic [15:0] PLANE_STRIDE = 16'h2000,
    parameter int unsigned READ_LAT     = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_pix,
    input  logic [8:0]  h,
    input  logic [8:0]  v,
    output logic [15:0] vram_addr,
    output logic        vram_rd,
    input  logic [7:0]  vram_data,
    output logic [7:0]  bg1,
    output logic [7:0]  bg2,
    output logic [7:0]  bg3,
    output logic [7:0]  fg1,
    output logic [7:0]  fg2,
    output logic [7:0]  fg3,
    output logic        busy,
    output logic        overrun
);

    localparam logic [8:0] H_TRIG_LIM = 9'(H_ACTIVE - 8);
    localparam logic [8:0] H_WRAP     = 9'(H_TOTAL - 8);
    localparam logic [9:0] V_LIM      = 10'(V_ACTIVE);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          n_q, n_d;
    logic                rd_q, rd_d;
    logic [15:0]         addr_q, addr_d;
    logic                discard_q, discard_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          shadow_q [6];
    logic [7:0]          shadow_d [6];
    logic [7:0]          out_q [6];
    logic [7:0]          out_d [6];
    logic [READ_LAT-1:0] rdp_q, rdp_d;
    logic [2:0]          idxp_q [READ_LAT];
    logic [2:0]          idxp_d [READ_LAT];

    logic        trig, load, in_win, cap, last_cap, fetch_ok;
    logic [2:0]  cap_idx;
    logic [5:0]  tc;
    logic [9:0]  tv;
    logic [15:0] start_addr;

    always_comb begin
        tc   = h[8:3] + 6'd1;
        tv   = {1'b0, v};
        trig = 1'b0;
        if (ce_pix && h[2:0] == 3'd0) begin
            if (h < H_TRIG_LIM) begin
                trig = 1'b1;
            end else if (h == H_WRAP) begin
                trig = 1'b1;
                tc   = 6'd0;
                tv   = {1'b0, v} + 10'd1;
            end
        end
        in_win     = tv < V_LIM;
        start_addr = 16'(32'(PLANE_BASE) + 32'(tv) * LINE_BYTES + 32'(tc));
    end

    assign load     = ce_pix && h[2:0] == 3'd7;
    assign cap      = rdp_q[READ_LAT-1];
    assign cap_idx  = idxp_q[READ_LAT-1];
    assign last_cap = cap && cap_idx == 3'd5;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        rd_d      = 1'b0;
        addr_d    = addr_q;
        discard_d = discard_q;
        overrun_d = overrun_q;
        shadow_d  = shadow_q;
        out_d     = out_q;
        rdp_d[0]  = rd_q;
        idxp_d[0] = n_q;
        for (int unsigned i = 1; i < READ_LAT; i++) begin
            rdp_d[i]  = rdp_q[i-1];
            idxp_d[i] = idxp_q[i-1];
        end

        if (cap && !discard_q) begin
            shadow_d[cap_idx] = vram_data;
        end

        case (state_q)
            S_ISSUE: begin
                if (n_q == 3'd5) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_d   = 1'b1;
                    n_d    = n_q + 3'd1;
                    addr_d = addr_q + PLANE_STRIDE;
                end
            end
            S_DRAIN: begin
                if (last_cap) begin
                    state_d = discard_q ? S_IDLE : S_DONE;
                end
            end
            default: ;
        endcase

        // The last byte landing on the LOAD edge still counts as an in-time fetch.
        fetch_ok = (state_q == S_DONE) || (state_q == S_DRAIN && last_cap && !discard_q);

        if (load) begin
            if (fetch_ok) begin
                out_d   = shadow_d;
                state_d = S_IDLE;
            end else if (state_q == S_IDLE) begin
                out_d = shadow_d;
            end else begin
                overrun_d = 1'b1;
                discard_d = 1'b1;
                for (int i = 0; i < 6; i++) out_d[i] = 8'd0;
            end
            for (int i = 0; i < 6; i++) shadow_d[i] = 8'd0;
        end

        if (trig) begin
            if (state_d == S_IDLE) begin
                if (in_win) begin
                    state_d   = S_ISSUE;
                    n_d       = 3'd0;
                    rd_d      = 1'b1;
                    addr_d    = start_addr;
                    discard_d = 1'b0;
                end else begin
                    for (int i = 0; i < 6; i++) shadow_d[i] = 8'd0;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            n_q       <= 3'd0;
            rd_q      <= 1'b0;
            addr_q    <= 16'd0;
            discard_q <= 1'b0;
            overrun_q <= 1'b0;
            rdp_q     <= '0;
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= 8'd0;
                out_q[i]    <= 8'd0;
            end
            for (int unsigned i = 0; i < READ_LAT; i++) idxp_q[i] <= 3'd0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
            overrun_q <= overrun_d;
            rdp_q     <= rdp_d;
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= shadow_d[i];
                out_q[i]    <= out_d[i];
            end
            for (int unsigned i = 0; i < READ_LAT; i++) idxp_q[i] <= idxp_d[i];
        end
    end

    assign vram_addr = addr_q;
    assign vram_rd   = rd_q;
    assign bg1       = out_q[0];
    assign bg2       = out_q[1];
    assign bg3       = out_q[2];
    assign fg1       = out_q[3];
    assign fg2       = out_q[4];
    assign fg3       = out_q[5];
    assign busy      = state_q != S_IDLE;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_rx78_plane_fetch.sv
// tb/tb_rx78_plane_fetch.sv - scoreboard bench driving READ_LAT=1 and READ_LAT=3
// instances of rx78_plane_fetch with a shared beam.
module tb_rx78_plane_fetch;

    logic        clk;
    logic        reset_n;
    logic        ce_pix;
    logic [8:0]  h;
    logic [8:0]  v;

    logic [15:0] d1_addr, d3_addr;
    logic        d1_rd, d3_rd, d1_busy, d3_busy, d1_ovr, d3_ovr;
    logic [7:0]  vd1, vd3;
    logic [7:0]  d1_b1, d1_b2, d1_b3, d1_f1, d1_f2, d1_f3;
    logic [7:0]  d3_b1, d3_b2, d3_b3, d3_f1, d3_f2, d3_f3;
    logic [47:0] d1_out, d3_out;

    int          n_err;
    int          n_checks;
    logic [15:0] q1[$];
    logic [15:0] q3[$];
    bit          trk3;

    logic [7:0]  m1;
    logic [7:0]  m3 [3];

    rx78_plane_fetch #(.READ_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .h(h), .v(v),
        .vram_addr(d1_addr), .vram_rd(d1_rd), .vram_data(vd1),
        .bg1(d1_b1), .bg2(d1_b2), .bg3(d1_b3), .fg1(d1_f1), .fg2(d1_f2), .fg3(d1_f3),
        .busy(d1_busy), .overrun(d1_ovr)
    );

    rx78_plane_fetch #(.READ_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .h(h), .v(v),
        .vram_addr(d3_addr), .vram_rd(d3_rd), .vram_data(vd3),
        .bg1(d3_b1), .bg2(d3_b2), .bg3(d3_b3), .fg1(d3_f1), .fg2(d3_f2), .fg3(d3_f3),
        .busy(d3_busy), .overrun(d3_ovr)
    );

    assign d1_out = {d1_b1, d1_b2, d1_b3, d1_f1, d1_f2, d1_f3};
    assign d3_out = {d3_b1, d3_b2, d3_b3, d3_f1, d3_f2, d3_f3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte stored at an address: 10 + plane index + byte offset inside the plane.
    function automatic logic [7:0] mem(input logic [15:0] a);
        return 8'(10 + int'(a[15:13]) + int'(a[12:0]) - 'h0ec0);
    endfunction

    function automatic logic [47:0] exp_cell(input int tc, input int tv);
        logic [47:0] r;
        r = '0;
        for (int n = 0; n < 6; n++) r[47-8*n -: 8] = 8'(10 + n + tv * 24 + tc);
        return r;
    endfunction

    always @(posedge clk) begin
        m1    <= d1_rd ? mem(d1_addr) : 8'hEE;
        m3[0] <= d3_rd ? mem(d3_addr) : 8'hEE;
        m3[1] <= m3[0];
        m3[2] <= m3[1];
    end
    assign vd1 = m1;
    assign vd3 = m3[2];

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (d1_rd) begin
                chk("rd1_expected", 48'(q1.size() > 0), 48'd1);
                if (q1.size() > 0) chk("rd1_addr", 48'(d1_addr), 48'(q1.pop_front()));
            end
            if (trk3 && d3_rd) begin
                chk("rd3_expected", 48'(q3.size() > 0), 48'd1);
                if (q3.size() > 0) chk("rd3_addr", 48'(d3_addr), 48'(q3.pop_front()));
            end
        end
    end

    task automatic tick(input bit ce);
        int tc, tv;
        ce_pix = ce;
        if (ce && h[2:0] == 3'd0 && (h < 9'd184 || h == 9'd248)) begin
            tc = (h == 9'd248) ? 0 : int'(h[8:3]) + 1;
            tv = (h == 9'd248) ? int'(v) + 1 : int'(v);
            if (tv < 184) begin
                for (int n = 0; n < 6; n++) begin
                    q1.push_back(16'('h0ec0 + n * 'h2000 + tv * 24 + tc));
                    if (trk3) q3.push_back(16'('h0ec0 + n * 'h2000 + tv * 24 + tc));
                end
            end
        end
        @(posedge clk);
        #1;
        if (ce) begin
            if (h == 9'd255) begin
                h = 9'd0;
                v = v + 9'd1;
            end else begin
                h = h + 9'd1;
            end
        end
    endtask

    task automatic pix();
        tick(1'b1);
        repeat (3) tick(1'b0);
    endtask

    task automatic do_reset(input int h0, input int v0);
        reset_n = 1'b0;
        ce_pix  = 1'b0;
        h       = 9'(h0);
        v       = 9'(v0);
        q1.delete();
        q3.delete();
        tick(1'b0);
        tick(1'b0);
        reset_n = 1'b1;
        tick(1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        n_err = 0; n_checks = 0; trk3 = 1'b1;
        reset_n = 1'b0; ce_pix = 1'b0; h = 9'd0; v = 9'd0;

        do_reset(0, 0);
        @(negedge clk);
        chk("rst_out1", d1_out, 48'd0);
        chk("rst_out3", d3_out, 48'd0);
        chk("rst_busy1", 48'(d1_busy), 48'd0);
        chk("rst_rd1", 48'(d1_rd), 48'd0);
        chk("rst_addr1", 48'(d1_addr), 48'd0);
        chk("rst_ovr1", 48'(d1_ovr), 48'd0);

        // Slow pixel clock, line 0
        repeat (8) pix();
        @(negedge clk);
        chk("c1_out1", d1_out, exp_cell(1, 0));
        chk("c1_out3", d3_out, exp_cell(1, 0));
        repeat (8) pix();
        @(negedge clk);
        chk("c2_out1", d1_out, exp_cell(2, 0));
        chk("c2_out3", d3_out, exp_cell(2, 0));
        repeat (168) pix();
        @(negedge clk);
        chk("c23_out1", d1_out, exp_cell(23, 0));
        chk("c23_out3", d3_out, exp_cell(23, 0));
        repeat (8) pix();
        @(negedge clk);
        chk("hblank_out1", d1_out, 48'd0);
        chk("hblank_busy1", 48'(d1_busy), 48'd0);
        repeat (64) pix();
        @(negedge clk);
        chk("l1c0_out1", d1_out, exp_cell(0, 1));
        chk("l1c0_out3", d3_out, exp_cell(0, 1));
        chk("slow_ovr1", 48'(d1_ovr), 48'd0);
        chk("slow_ovr3", 48'(d3_ovr), 48'd0);
        repeat (20) tick(1'b0);
        chk("slow_q1_empty", 48'(q1.size()), 48'd0);
        chk("slow_q3_empty", 48'(q3.size()), 48'd0);

        // Line-wrap trigger from v=4 targets column 0 of line 5
        do_reset(248, 4);
        tick(1'b1);
        @(negedge clk);
        chk("wrap_rd1", 48'(d1_rd), 48'd1);
        chk("wrap_addr1", 48'(d1_addr), 48'h0f38);
        repeat (3) tick(1'b0);
        repeat (7) pix();
        @(negedge clk);
        chk("wrap_out1", d1_out, exp_cell(0, 5));
        chk("wrap_out3", d3_out, exp_cell(0, 5));

        // Last active line and the out-of-window wrap to line 184
        do_reset(176, 183);
        repeat (8) pix();
        @(negedge clk);
        chk("last_c23_out1", d1_out, exp_cell(23, 183));
        repeat (8) pix();
        @(negedge clk);
        chk("last_blank_out1", d1_out, 48'd0);
        repeat (64) pix();
        @(negedge clk);
        chk("v184_out1", d1_out, 48'd0);
        chk("v184_out3", d3_out, 48'd0);
        chk("v184_busy1", 48'(d1_busy), 48'd0);
        repeat (8) pix();
        @(negedge clk);
        chk("v184_c1_out1", d1_out, 48'd0);
        chk("v184_q1_empty", 48'(q1.size()), 48'd0);

        // Reset asserted while the fetch is issuing
        do_reset(0, 0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        @(negedge clk);
        chk("mid_rd1_active", 48'(d1_rd), 48'd1);
        reset_n = 1'b0;
        q1.delete();
        q3.delete();
        @(posedge clk);
        #1;
        chk("mid_busy1", 48'(d1_busy), 48'd0);
        chk("mid_rd1", 48'(d1_rd), 48'd0);
        chk("mid_busy3", 48'(d3_busy), 48'd0);
        chk("mid_rd3", 48'(d3_rd), 48'd0);
        do_reset(1, 0);
        repeat (7) pix();
        @(negedge clk);
        chk("post_rst_out1", d1_out, 48'd0);
        chk("post_rst_busy1", 48'(d1_busy), 48'd0);
        repeat (8) pix();
        @(negedge clk);
        chk("post_rst_c2_out1", d1_out, exp_cell(2, 0));
        chk("post_rst_c2_out3", d3_out, exp_cell(2, 0));

        // Pixel enable every clock: READ_LAT=1 keeps up, READ_LAT=3 overruns
        do_reset(0, 0);
        trk3 = 1'b0;
        repeat (8) tick(1'b1);
        @(negedge clk);
        chk("fast_c1_out1", d1_out, exp_cell(1, 0));
        chk("fast_ovr1", 48'(d1_ovr), 48'd0);
        chk("fast_ovr3", 48'(d3_ovr), 48'd1);
        chk("fast_c1_out3", d3_out, 48'd0);
        repeat (8) tick(1'b1);
        @(negedge clk);
        chk("fast_c2_out1", d1_out, exp_cell(2, 0));
        chk("fast_c2_out3", d3_out, 48'd0);
        repeat (16) tick(1'b1);
        repeat (20) tick(1'b0);
        chk("fast_ovr3_sticky", 48'(d3_ovr), 48'd1);
        chk("fast_ovr1_end", 48'(d1_ovr), 48'd0);
        chk("fast_q1_empty", 48'(q1.size()), 48'd0);
        trk3 = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
